c3_custom_issue: RTL and testbench

- Core-side initiator for the C3 custom-instruction port. Drives in_v/rd/in_data into the accelerator and honours its busy. Collects out_v/out_rd/out_data and turns them into a register-file writeback.
- Sits between the core's decode/execute stage and the accelerator. Exposes a scoreboard entry so the pipeline can stall on a pending destination register.
- One instruction outstanding at a time. rd==0 is a push (no response); rd!=0 is a pop (exactly one response expected).

---
 rtl/c3_custom_issue.sv | 185 ++++++++++++++++++
 tb/tb_c3_custom_issue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/c3_custom_issue.sv
// C3 custom-instruction initiator: issues one op to the accelerator,
// tracks the pending destination and turns the response into a writeback.
module c3_custom_issue #(
  parameter int XLEN      = 32,
  parameter int ISSUE_GAP = 2,
  parameter int TIMEOUT   = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_v,
  output logic            req_ready,
  input  logic [4:0]      req_rd,
  input  logic [XLEN-1:0] req_data,
  output logic            acc_in_v,
  output logic [4:0]      acc_rd,
  output logic [XLEN-1:0] acc_data,
  input  logic            acc_busy,
  input  logic            acc_out_v,
  input  logic [4:0]      acc_out_rd,
  input  logic [XLEN-1:0] acc_out_data,
  output logic            wb_v,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            pend_v,
  output logic [4:0]      pend_rd,
  output logic [2:0]      err,
  input  logic            clr_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_WAIT_BUSY,
    S_WAIT_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic [3:0]      gap_q, gap_d;
  logic [15:0]     wcnt_q, wcnt_d;
  logic            acc_in_v_q, acc_in_v_d;
  logic [4:0]      acc_rd_q, acc_rd_d;
  logic [XLEN-1:0] acc_data_q, acc_data_d;
  logic            wb_v_q, wb_v_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            pend_v_q, pend_v_d;
  logic [4:0]      pend_rd_q, pend_rd_d;
  logic [2:0]      err_q, err_d;
  logic [2:0]      err_set;
  logic            is_pop;
  logic            cap;
  logic            tmo;

  assign is_pop = (rd_q != 5'd0);
  assign tmo    = (wcnt_q == 16'(TIMEOUT - 1));
  assign cap    = acc_out_v && is_pop &&
                  (state_q == S_GAP || state_q == S_WAIT_RESP);

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    gap_d      = gap_q;
    wcnt_d     = wcnt_q;
    acc_in_v_d = 1'b0;
    acc_rd_d   = acc_rd_q;
    acc_data_d = acc_data_q;
    wb_v_d     = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    pend_v_d   = pend_v_q;
    pend_rd_d  = pend_rd_q;
    err_set    = 3'b000;

    // Any response outside a pop's capture window is stray.
    if (acc_out_v && !cap) err_set[2] = 1'b1;

    if (cap) begin
      wb_v_d    = 1'b1;
      wb_rd_d   = rd_q;
      wb_data_d = acc_out_data;
      state_d   = S_IDLE;
      if (acc_out_rd != rd_q) err_set[1] = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          pend_v_d = 1'b0;
          if (req_v) begin
            rd_d       = req_rd;
            acc_in_v_d = 1'b1;
            acc_rd_d   = req_rd;
            acc_data_d = req_data;
            state_d    = S_ISSUE;
            if (req_rd != 5'd0) begin
              pend_v_d  = 1'b1;
              pend_rd_d = req_rd;
            end
          end
        end
        S_ISSUE: begin
          gap_d   = 4'(ISSUE_GAP);
          state_d = S_GAP;
        end
        S_GAP: begin
          if (gap_q <= 4'd1) begin
            wcnt_d  = 16'd0;
            state_d = is_pop ? S_WAIT_RESP : S_WAIT_BUSY;
          end else begin
            gap_d = gap_q - 4'd1;
          end
        end
        S_WAIT_BUSY: begin
          if (!acc_busy) begin
            state_d = S_IDLE;
          end else if (tmo) begin
            err_set[0] = 1'b1;
            state_d    = S_IDLE;
          end else begin
            wcnt_d = wcnt_q + 16'd1;
          end
        end
        S_WAIT_RESP: begin
          // An unanswered pop still writes back zero so dependents drain.
          if (tmo) begin
            err_set[0] = 1'b1;
            wb_v_d     = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = '0;
            state_d    = S_IDLE;
          end else begin
            wcnt_d = wcnt_q + 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    err_d = (clr_err ? 3'b000 : err_q) | err_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_q       <= '0;
      gap_q      <= '0;
      wcnt_q     <= '0;
      acc_in_v_q <= 1'b0;
      acc_rd_q   <= '0;
      acc_data_q <= '0;
      wb_v_q     <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      pend_v_q   <= 1'b0;
      pend_rd_q  <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      gap_q      <= gap_d;
      wcnt_q     <= wcnt_d;
      acc_in_v_q <= acc_in_v_d;
      acc_rd_q   <= acc_rd_d;
      acc_data_q <= acc_data_d;
      wb_v_q     <= wb_v_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      pend_v_q   <= pend_v_d;
      pend_rd_q  <= pend_rd_d;
      err_q      <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign acc_in_v  = acc_in_v_q;
  assign acc_rd    = acc_rd_q;
  assign acc_data  = acc_data_q;
  assign wb_v      = wb_v_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign pend_v    = pend_v_q;
  assign pend_rd   = pend_rd_q;
  assign err       = err_q;

endmodule

// File: tb/tb_c3_custom_issue.sv
// Scoreboard bench for c3_custom_issue: driver plays core and accelerator,
// monitor pops expected issues/writebacks as the DUT presents them.
module tb_c3_custom_issue;
  localparam int XLEN = 32;
  localparam int G    = 2;
  localparam int TMO  = 256;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_v;
  logic            req_ready;
  logic [4:0]      req_rd;
  logic [XLEN-1:0] req_data;
  logic            acc_in_v;
  logic [4:0]      acc_rd;
  logic [XLEN-1:0] acc_data;
  logic            acc_busy;
  logic            acc_out_v;
  logic [4:0]      acc_out_rd;
  logic [XLEN-1:0] acc_out_data;
  logic            wb_v;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            pend_v;
  logic [4:0]      pend_rd;
  logic [2:0]      err;
  logic            clr_err;

  always #5 clk = ~clk;

  c3_custom_issue #(
    .XLEN(XLEN), .ISSUE_GAP(G), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_v(req_v), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .acc_in_v(acc_in_v), .acc_rd(acc_rd), .acc_data(acc_data),
    .acc_busy(acc_busy), .acc_out_v(acc_out_v),
    .acc_out_rd(acc_out_rd), .acc_out_data(acc_out_data),
    .wb_v(wb_v), .wb_rd(wb_rd), .wb_data(wb_data),
    .pend_v(pend_v), .pend_rd(pend_rd),
    .err(err), .clr_err(clr_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t        iss_q[$];
  ev_t        wb_q[$];
  ev_t        me;
  int         checks   = 0;
  int         failures = 0;
  int         ncyc     = 0;
  logic [2:0] exp_err;

  always @(posedge clk) ncyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h",
               nm, ncyc, act, exp);
    end
  endtask

  // Monitor: every issue strobe and writeback must match the head entry.
  always @(negedge clk) begin
    if (acc_in_v) begin
      if (iss_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL iss_unexpected cyc=%0d rd=%0d", ncyc, acc_rd);
      end else begin
        me = iss_q.pop_front();
        chk("iss_rd", 32'(acc_rd), 32'(me.rd));
        chk("iss_data", acc_data, me.data);
        chk("iss_cyc", 32'(ncyc), 32'(me.cyc));
      end
    end
    if (wb_v) begin
      if (wb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected cyc=%0d rd=%0d", ncyc, wb_rd);
      end else begin
        me = wb_q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(me.rd));
        chk("wb_data", wb_data, me.data);
        chk("wb_cyc", 32'(ncyc), 32'(me.cyc));
      end
    end
  end

  // One transaction. Cycle T is the cycle req_v is presented with
  // req_ready high; input driven at cycle T+j is sampled at its end.
  task automatic do_op(input bit pop, input logic [4:0] rd,
                       input logic [31:0] d, input int blen,
                       input bit resp, input int k,
                       input logic [4:0] rrd, input logic [31:0] rdat);
    int  t, j, endj, w;
    ev_t e;
    w = 0;
    while (!req_ready && w < 64) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_op", 32'(req_ready), 32'd1);
    t        = ncyc;
    req_v    = 1'b1;
    req_rd   = pop ? rd : 5'd0;
    req_data = d;
    e.rd = pop ? rd : 5'd0;
    e.data = d;
    e.cyc = t + 1;
    iss_q.push_back(e);
    if (pop) begin
      // Issue at T+1, G gap cycles, then response or TMO wait cycles.
      endj = resp ? k + 2 : G + TMO + 3;
      e.rd = rd;
      e.data = resp ? rdat : 32'd0;
      e.cyc = t + endj - 1;
      wb_q.push_back(e);
      if (!resp) exp_err[0] = 1'b1;
      else if (rrd != rd) exp_err[1] = 1'b1;
    end else begin
      endj = ((blen > G) ? blen : G) + 3;
    end
    j = 0;
    while (j < endj) begin
      @(negedge clk);
      j            = ncyc - t;
      req_v        = 1'b0;
      acc_busy     = !pop && j >= 2 && j < 2 + blen;
      acc_out_v    = pop && resp && j == k;
      acc_out_rd   = rrd;
      acc_out_data = rdat;
      if (pop) begin
        chk("pend_v", 32'(pend_v), 32'(j < endj));
        if (j < endj) chk("pend_rd", 32'(pend_rd), 32'(rd));
        chk("ready_pop", 32'(req_ready), 32'(j >= endj - 1));
      end else begin
        chk("pend_v_push", 32'(pend_v), 32'd0);
        chk("ready_push", 32'(req_ready), 32'(j >= endj));
      end
    end
    acc_busy  = 1'b0;
    acc_out_v = 1'b0;
    chk("err", 32'(err), 32'(exp_err));
  endtask

  task automatic stray(input bit clr);
    acc_out_v    = 1'b1;
    acc_out_rd   = 5'($urandom);
    acc_out_data = $urandom;
    clr_err      = clr;
    @(negedge clk);
    acc_out_v = 1'b0;
    clr_err   = 1'b0;
    exp_err   = (clr ? 3'b000 : exp_err) | 3'b100;
    chk("stray_err", 32'(err), 32'(exp_err));
    chk("stray_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic clear();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_err = 3'b000;
    chk("clr_err", 32'(err), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired cyc=%0d", ncyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  rd;
    logic [31:0] dat;
    ev_t         e;
    int          t;
    bit          pop;
    reset        = 1'b1;
    req_v        = 1'b0;
    req_rd       = '0;
    req_data     = '0;
    acc_busy     = 1'b0;
    acc_out_v    = 1'b0;
    acc_out_rd   = '0;
    acc_out_data = '0;
    clr_err      = 1'b0;
    exp_err      = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_acc_in_v", 32'(acc_in_v), 32'd0);
    chk("rst_wb_v", 32'(wb_v), 32'd0);
    chk("rst_pend_v", 32'(pend_v), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    do_op(1'b0, 5'd0, 32'h5, 4, 1'b0, 0, 5'd0, 32'd0);
    do_op(1'b1, 5'd7, 32'h1234, 0, 1'b1, 5, 5'd7, 32'h2A);
    do_op(1'b1, 5'd3, 32'h77, 0, 1'b1, 3, 5'd3, 32'h11);
    do_op(1'b1, 5'd9, 32'h0, 0, 1'b0, 0, 5'd9, 32'hDEAD);
    clear();
    do_op(1'b1, 5'd4, 32'h8, 0, 1'b1, 6, 5'd5, 32'h99);
    stray(1'b0);
    clear();
    stray(1'b1);
    clear();
    do_op(1'b0, 5'd0, 32'hCAFE, 0, 1'b0, 0, 5'd0, 32'd0);

    for (int n = 0; n < 40; n++) begin
      pop = 1'($urandom_range(0, 1));
      rd  = pop ? 5'($urandom_range(1, 31)) : 5'd0;
      dat = $urandom;
      do_op(pop, rd, dat, $urandom_range(0, 6),
            $urandom_range(0, 9) != 0, $urandom_range(3, 12),
            ($urandom_range(0, 4) == 0) ? rd ^ 5'd1 : rd, $urandom);
      if ($urandom_range(0, 3) == 0) clear();
    end
    clear();

    // Reset while a pop sits in WAIT_RESP drops it without writeback.
    chk("rst_test_ready", 32'(req_ready), 32'd1);
    t        = ncyc;
    req_v    = 1'b1;
    req_rd   = 5'd12;
    req_data = 32'hABCD;
    e.rd = 5'd12;
    e.data = 32'hABCD;
    e.cyc = t + 1;
    iss_q.push_back(e);
    @(negedge clk);
    req_v = 1'b0;
    while (ncyc < t + G + 3) @(negedge clk);
    chk("rst_test_pend", 32'(pend_v), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_acc_in_v", 32'(acc_in_v), 32'd0);
    chk("mid_rst_acc_rd", 32'(acc_rd), 32'd0);
    chk("mid_rst_acc_data", acc_data, 32'd0);
    chk("mid_rst_wb_v", 32'(wb_v), 32'd0);
    chk("mid_rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    chk("mid_rst_pend", 32'(pend_v), 32'd0);
    chk("mid_rst_pend_rd", 32'(pend_rd), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    reset   = 1'b0;
    exp_err = 3'b000;
    @(negedge clk);
    stray(1'b0);
    chk("late_wb_v", 32'(wb_v), 32'd0);
    clear();

    repeat (3) @(negedge clk);
    chk("iss_q_drained", 32'(iss_q.size()), 32'd0);
    chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
